// File: rtl/bus_arbiter.sv
// Two-to-one round-robin Wishbone arbiter merging the core instruction port
// (wish_in0) and data port (wish_in1) onto one shared bus (wish_out).
// The grant is registered. Request signals and ack/data are routed
// combinationally. A watchdog releases the bus when a secondary never acks.
module bus_arbiter #(
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,

    // port 0: core instruction port
    input  logic                   wish_in0_cyc,
    input  logic                   wish_in0_stb,
    input  logic                   wish_in0_we,
    input  logic                   wish_in0_tgd,
    input  logic [DATA_SIZE-1:0]   wish_in0_addr,
    input  logic [DATA_SIZE/8-1:0] wish_in0_sel,
    input  logic [DATA_SIZE-1:0]   wish_in0_dat_o_p,
    output logic                   wish_in0_ack,
    output logic [DATA_SIZE-1:0]   wish_in0_dat_i_p,

    // port 1: core data port
    input  logic                   wish_in1_cyc,
    input  logic                   wish_in1_stb,
    input  logic                   wish_in1_we,
    input  logic                   wish_in1_tgd,
    input  logic [DATA_SIZE-1:0]   wish_in1_addr,
    input  logic [DATA_SIZE/8-1:0] wish_in1_sel,
    input  logic [DATA_SIZE-1:0]   wish_in1_dat_o_p,
    output logic                   wish_in1_ack,
    output logic [DATA_SIZE-1:0]   wish_in1_dat_i_p,

    // shared bus toward the interconnect
    output logic                   wish_out_cyc,
    output logic                   wish_out_stb,
    output logic                   wish_out_we,
    output logic                   wish_out_tgd,
    output logic [DATA_SIZE-1:0]   wish_out_addr,
    output logic [DATA_SIZE/8-1:0] wish_out_sel,
    output logic [DATA_SIZE-1:0]   wish_out_dat_o_p,
    input  logic                   wish_out_ack,
    input  logic [DATA_SIZE-1:0]   wish_out_dat_i_p,

    output logic                   bus_timeout
);

    // Counter must hold TIMEOUT_CYCLES-1; keep at least one bit when the
    // watchdog is disabled so the declarations stay legal.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WLIM = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] WMAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            last;
    logic [CW-1:0]   wcnt;
    logic            granted;
    logic            timeout_hit;
    logic            done;
    logic            entering;

    // Next-state selection: round-robin in IDLE, other-port-first after a
    // completed (or timed-out) transaction, and abort on a dropped cyc.
    always_comb begin
        next_state  = state;
        granted     = (state != IDLE);
        timeout_hit = 1'b0;
        if ((TIMEOUT_CYCLES != 0) && granted && !wish_out_ack && (wcnt == WLIM))
            timeout_hit = 1'b1;
        done = wish_out_ack || timeout_hit;
        case (state)
            IDLE: begin
                if (wish_in0_cyc && wish_in1_cyc)
                    next_state = last ? GRANT0 : GRANT1;
                else if (wish_in0_cyc)
                    next_state = GRANT0;
                else if (wish_in1_cyc)
                    next_state = GRANT1;
            end
            GRANT0: begin
                if (done) begin
                    if (wish_in1_cyc)      next_state = GRANT1;
                    else if (wish_in0_cyc) next_state = GRANT0;
                    else                   next_state = IDLE;
                end else if (!wish_in0_cyc) begin
                    next_state = IDLE;
                end
            end
            GRANT1: begin
                if (done) begin
                    if (wish_in0_cyc)      next_state = GRANT0;
                    else if (wish_in1_cyc) next_state = GRANT1;
                    else                   next_state = IDLE;
                end else if (!wish_in1_cyc) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // A grant is (re)entered from IDLE or at the end of a transaction.
        entering = (next_state != IDLE) && ((state == IDLE) || done);
    end

    // Grant state and the round-robin memory of the last granted port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state == GRANT0)      last <= 1'b0;
            else if (next_state == GRANT1) last <= 1'b1;
        end
    end

    // Watchdog counter: cleared on each grant entry, saturating while waiting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt <= '0;
        end else if (entering) begin
            wcnt <= '0;
        end else if (granted && !wish_out_ack && (wcnt != WMAX)) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // Bus mux toward the interconnect and ack/data return to the owner.
    always_comb begin
        wish_out_cyc     = 1'b0;
        wish_out_stb     = 1'b0;
        wish_out_we      = 1'b0;
        wish_out_tgd     = 1'b0;
        wish_out_addr    = '0;
        wish_out_sel     = '0;
        wish_out_dat_o_p = '0;
        wish_in0_ack     = 1'b0;
        wish_in0_dat_i_p = '0;
        wish_in1_ack     = 1'b0;
        wish_in1_dat_i_p = '0;
        bus_timeout      = timeout_hit;
        if (state == GRANT0) begin
            wish_out_cyc     = wish_in0_cyc && !timeout_hit;
            wish_out_stb     = wish_in0_stb && !timeout_hit;
            wish_out_we      = wish_in0_we;
            wish_out_tgd     = wish_in0_tgd;
            wish_out_addr    = wish_in0_addr;
            wish_out_sel     = wish_in0_sel;
            wish_out_dat_o_p = wish_in0_dat_o_p;
            wish_in0_ack     = wish_out_ack || timeout_hit;
            wish_in0_dat_i_p = timeout_hit ? '0 : wish_out_dat_i_p;
        end else if (state == GRANT1) begin
            wish_out_cyc     = wish_in1_cyc && !timeout_hit;
            wish_out_stb     = wish_in1_stb && !timeout_hit;
            wish_out_we      = wish_in1_we;
            wish_out_tgd     = wish_in1_tgd;
            wish_out_addr    = wish_in1_addr;
            wish_out_sel     = wish_in1_sel;
            wish_out_dat_o_p = wish_in1_dat_o_p;
            wish_in1_ack     = wish_out_ack || timeout_hit;
            wish_in1_dat_i_p = timeout_hit ? '0 : wish_out_dat_i_p;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (watchdog set to 4 cycles).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        in0_cyc, in0_stb, in0_we, in0_tgd;
    logic [31:0] in0_addr, in0_dat_o_p, in0_dat_i_p;
    logic [3:0]  in0_sel;
    logic        in0_ack;
    logic        in1_cyc, in1_stb, in1_we, in1_tgd;
    logic [31:0] in1_addr, in1_dat_o_p, in1_dat_i_p;
    logic [3:0]  in1_sel;
    logic        in1_ack;
    logic        out_cyc, out_stb, out_we, out_tgd;
    logic [31:0] out_addr, out_dat_o_p, out_dat_i_p;
    logic [3:0]  out_sel;
    logic        out_ack;
    logic        bus_timeout;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.DATA_SIZE(32), .TIMEOUT_CYCLES(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .wish_in0_cyc     (in0_cyc),
        .wish_in0_stb     (in0_stb),
        .wish_in0_we      (in0_we),
        .wish_in0_tgd     (in0_tgd),
        .wish_in0_addr    (in0_addr),
        .wish_in0_sel     (in0_sel),
        .wish_in0_dat_o_p (in0_dat_o_p),
        .wish_in0_ack     (in0_ack),
        .wish_in0_dat_i_p (in0_dat_i_p),
        .wish_in1_cyc     (in1_cyc),
        .wish_in1_stb     (in1_stb),
        .wish_in1_we      (in1_we),
        .wish_in1_tgd     (in1_tgd),
        .wish_in1_addr    (in1_addr),
        .wish_in1_sel     (in1_sel),
        .wish_in1_dat_o_p (in1_dat_o_p),
        .wish_in1_ack     (in1_ack),
        .wish_in1_dat_i_p (in1_dat_i_p),
        .wish_out_cyc     (out_cyc),
        .wish_out_stb     (out_stb),
        .wish_out_we      (out_we),
        .wish_out_tgd     (out_tgd),
        .wish_out_addr    (out_addr),
        .wish_out_sel     (out_sel),
        .wish_out_dat_o_p (out_dat_o_p),
        .wish_out_ack     (out_ack),
        .wish_out_dat_i_p (out_dat_i_p),
        .bus_timeout      (bus_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive0(input logic cyc, input logic we, input logic tgd,
                          input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        in0_cyc = cyc; in0_stb = cyc; in0_we = we; in0_tgd = tgd;
        in0_addr = a; in0_sel = s; in0_dat_o_p = d;
    endtask

    task automatic drive1(input logic cyc, input logic we, input logic tgd,
                          input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        in1_cyc = cyc; in1_stb = cyc; in1_we = we; in1_tgd = tgd;
        in1_addr = a; in1_sel = s; in1_dat_o_p = d;
    endtask

    task automatic ports_idle();
        drive0(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic settle();
        @(negedge clock);
        ports_idle();
        out_ack = 1'b0;
        out_dat_i_p = 32'h0;
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        ports_idle();
        out_ack = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive0(1'b1, 1'b0, 1'b0, 32'h44, 4'hF, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        out_ack = 1'b1;
        out_dat_i_p = 32'h55AA55AA;
        repeat (2) @(negedge clock);
        #1;
        total++; if (out_cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b want=0", out_cyc); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", out_addr); end
        total++; if (in0_ack !== 1'b0) begin bad++; $display("FAIL rst_ack0 got=%b want=0", in0_ack); end
        total++; if (in0_dat_i_p !== 32'h0) begin bad++; $display("FAIL rst_dat0 got=%h want=0", in0_dat_i_p); end
        total++; if (bus_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", bus_timeout); end
        @(negedge clock);
        ports_idle();
        out_ack = 1'b0;
        out_dat_i_p = 32'h0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clock);
        drive0(1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
        out_ack = 1'b0;
        #1;
        total++; if (out_cyc !== 1'b0) begin bad++; $display("FAIL single_latency got=%b want=0", out_cyc); end
        @(negedge clock); #1;
        total++; if (out_cyc !== 1'b1) begin bad++; $display("FAIL single_cyc got=%b want=1", out_cyc); end
        total++; if (out_addr !== 32'h100) begin bad++; $display("FAIL single_addr got=%h want=100", out_addr); end
        total++; if (in0_ack !== 1'b0) begin bad++; $display("FAIL single_early_ack got=%b want=0", in0_ack); end
        @(negedge clock);
        out_ack = 1'b1;
        out_dat_i_p = 32'hDEADBEEF;
        #1;
        total++; if (in0_ack !== 1'b1) begin bad++; $display("FAIL single_ack0 got=%b want=1", in0_ack); end
        total++; if (in0_dat_i_p !== 32'hDEADBEEF) begin bad++; $display("FAIL single_dat0 got=%h want=deadbeef", in0_dat_i_p); end
        total++; if (in1_ack !== 1'b0) begin bad++; $display("FAIL single_ack1 got=%b want=0", in1_ack); end
        total++; if (in1_dat_i_p !== 32'h0) begin bad++; $display("FAIL single_dat1 got=%h want=0", in1_dat_i_p); end
        settle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clock);
        drive0(1'b1, 1'b0, 1'b0, 32'h200, 4'hF, 32'h0);
        drive1(1'b1, 1'b1, 1'b1, 32'h300, 4'h3, 32'h12345678);
        out_ack = 1'b0;
        #1;
        total++; if (out_cyc !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", out_cyc); end
        @(negedge clock);
        out_ack = 1'b1;
        out_dat_i_p = 32'h11111111;
        #1;
        total++; if (out_addr !== 32'h200) begin bad++; $display("FAIL b2b_first_addr got=%h want=200", out_addr); end
        total++; if (out_we !== 1'b0) begin bad++; $display("FAIL b2b_first_we got=%b want=0", out_we); end
        total++; if (in0_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack0 got=%b want=1", in0_ack); end
        total++; if (in1_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack1_blocked got=%b want=0", in1_ack); end
        @(negedge clock);
        out_ack = 1'b0;
        #1;
        total++; if (out_cyc !== 1'b1) begin bad++; $display("FAIL b2b_second_cyc got=%b want=1", out_cyc); end
        total++; if (out_addr !== 32'h300) begin bad++; $display("FAIL b2b_second_addr got=%h want=300", out_addr); end
        total++; if (out_we !== 1'b1) begin bad++; $display("FAIL b2b_second_we got=%b want=1", out_we); end
        total++; if (out_sel !== 4'h3) begin bad++; $display("FAIL b2b_second_sel got=%h want=3", out_sel); end
        total++; if (out_tgd !== 1'b1) begin bad++; $display("FAIL b2b_second_tgd got=%b want=1", out_tgd); end
        @(negedge clock);
        out_ack = 1'b1;
        out_dat_i_p = 32'hCAFEF00D;
        #1;
        total++; if (in1_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b want=1", in1_ack); end
        total++; if (in1_dat_i_p !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_dat1 got=%h want=cafef00d", in1_dat_i_p); end
        total++; if (in0_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack0_blocked got=%b want=0", in0_ack); end
        total++; if (in0_dat_i_p !== 32'h0) begin bad++; $display("FAIL b2b_dat0_blocked got=%h want=0", in0_dat_i_p); end
    endtask

    // Continues from test_back_to_back: both ports still requesting, port 1 just acked.
    task automatic test_fairness();
        for (int i = 0; i < 6; i++) begin
            logic        p1;
            logic [31:0] exp_addr;
            p1 = (i % 2) == 1;
            exp_addr = p1 ? 32'h300 : 32'h200;
            @(negedge clock);
            out_ack = 1'b1;
            out_dat_i_p = i;
            #1;
            total++; if (out_addr !== exp_addr) begin bad++; $display("FAIL fair_order[%0d] got=%h want=%h", i, out_addr, exp_addr); end
            total++; if (in1_ack !== p1) begin bad++; $display("FAIL fair_ack1[%0d] got=%b want=%b", i, in1_ack, p1); end
            total++; if (in0_ack !== !p1) begin bad++; $display("FAIL fair_ack0[%0d] got=%b want=%b", i, in0_ack, !p1); end
            if (p1) begin
                total++; if (out_dat_o_p !== 32'h12345678) begin bad++; $display("FAIL fair_store_dat[%0d] got=%h want=12345678", i, out_dat_o_p); end
                total++; if (out_sel !== 4'h3) begin bad++; $display("FAIL fair_store_sel[%0d] got=%h want=3", i, out_sel); end
            end
        end
        settle();
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clock);
        drive0(1'b1, 1'b0, 1'b0, 32'h400, 4'hF, 32'h0);
        drive1(1'b1, 1'b1, 1'b0, 32'h500, 4'hF, 32'h77);
        out_ack = 1'b0;
        out_dat_i_p = 32'hFFFFFFFF;
        for (int g = 1; g <= 4; g++) begin
            @(negedge clock); #1;
            if (g < 4) begin
                total++; if (bus_timeout !== 1'b0) begin bad++; $display("FAIL wd_early[%0d] got=%b want=0", g, bus_timeout); end
                total++; if (in0_ack !== 1'b0) begin bad++; $display("FAIL wd_early_ack[%0d] got=%b want=0", g, in0_ack); end
                total++; if (out_cyc !== 1'b1) begin bad++; $display("FAIL wd_cyc[%0d] got=%b want=1", g, out_cyc); end
            end else begin
                total++; if (bus_timeout !== 1'b1) begin bad++; $display("FAIL wd_pulse got=%b want=1", bus_timeout); end
                total++; if (in0_ack !== 1'b1) begin bad++; $display("FAIL wd_ack got=%b want=1", in0_ack); end
                total++; if (in0_dat_i_p !== 32'h0) begin bad++; $display("FAIL wd_dat got=%h want=0", in0_dat_i_p); end
                total++; if (out_cyc !== 1'b0) begin bad++; $display("FAIL wd_cyc_forced got=%b want=0", out_cyc); end
                total++; if (out_stb !== 1'b0) begin bad++; $display("FAIL wd_stb_forced got=%b want=0", out_stb); end
            end
        end
        @(negedge clock); #1;
        total++; if (out_addr !== 32'h500) begin bad++; $display("FAIL wd_next_grant got=%h want=500", out_addr); end
        total++; if (out_cyc !== 1'b1) begin bad++; $display("FAIL wd_next_cyc got=%b want=1", out_cyc); end
        total++; if (bus_timeout !== 1'b0) begin bad++; $display("FAIL wd_one_cycle got=%b want=0", bus_timeout); end
        settle();
    endtask

    task automatic test_abort();
        do_reset();
        @(negedge clock);
        drive1(1'b1, 1'b1, 1'b0, 32'h600, 4'hF, 32'hAA);
        out_ack = 1'b0;
        @(negedge clock); #1;
        total++; if (out_addr !== 32'h600) begin bad++; $display("FAIL abort_grant got=%h want=600", out_addr); end
        @(negedge clock);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive0(1'b1, 1'b0, 1'b0, 32'h700, 4'hF, 32'h0);
        #1;
        total++; if (in1_ack !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b want=0", in1_ack); end
        @(negedge clock); #1;
        total++; if (out_cyc !== 1'b0) begin bad++; $display("FAIL abort_idle_cyc got=%b want=0", out_cyc); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL abort_idle_addr got=%h want=0", out_addr); end
        @(negedge clock); #1;
        total++; if (out_cyc !== 1'b1) begin bad++; $display("FAIL abort_regrant_cyc got=%b want=1", out_cyc); end
        total++; if (out_addr !== 32'h700) begin bad++; $display("FAIL abort_regrant_addr got=%h want=700", out_addr); end
        settle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clock);
        drive0(1'b1, 1'b0, 1'b0, 32'h800, 4'hF, 32'h0);
        out_ack = 1'b0;
        @(negedge clock); #1;
        total++; if (out_cyc !== 1'b1) begin bad++; $display("FAIL rmid_granted got=%b want=1", out_cyc); end
        @(negedge clock);
        drive1(1'b1, 1'b1, 1'b0, 32'h900, 4'hF, 32'h5);
        out_ack = 1'b1;
        out_dat_i_p = 32'h13572468;
        reset = 1'b0;
        #1;
        total++; if (out_cyc !== 1'b0) begin bad++; $display("FAIL rmid_cyc got=%b want=0", out_cyc); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%h want=0", out_addr); end
        total++; if (in0_ack !== 1'b0) begin bad++; $display("FAIL rmid_ack got=%b want=0", in0_ack); end
        @(negedge clock);
        reset = 1'b1;
        out_ack = 1'b0;
        #1;
        total++; if (out_cyc !== 1'b0) begin bad++; $display("FAIL rmid_release_idle got=%b want=0", out_cyc); end
        @(negedge clock); #1;
        total++; if (out_addr !== 32'h800) begin bad++; $display("FAIL rmid_first_grant got=%h want=800", out_addr); end
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
